// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry front end.
package keypad_pkg;

    localparam int KEY_W = 4;

    localparam int DEF_ENTER_CODE = 14;
    localparam int DEF_CLEAR_CODE = 15;
    localparam int DEF_BKSP_CODE  = 13;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_ACCEPT,
        ST_RELEASE
    } scan_state_t;

endpackage

// File: rtl/keypad_scanner.sv
// Matrix scanner: row synchroniser, scan prescaler, debounce FSM.
// Emits a one-cycle accept pulse with the code of the debounced key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ROWS-1:0]  key_row,
    output logic [COLS-1:0]  key_col,
    output logic             accept,
    output logic [KEY_W-1:0] key_code
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    scan_state_t   state;
    logic [ROWS-1:0] row_meta;
    logic [ROWS-1:0] row_sync;
    logic [PW-1:0] presc;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_lat;
    logic [DW-1:0] stab_cnt;
    logic [DW-1:0] rel_cnt;
    logic          tick;
    logic          row_any;
    logic [RW-1:0] row_low;

    function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] rows);
        lowest_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (rows[r]) lowest_row = RW'(r);
        end
    endfunction

    function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
        next_col = (c == CW'(COLS - 1)) ? '0 : c + CW'(1);
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] c);
        col_onehot = COLS'(1) << c;
    endfunction

    assign tick     = enable && (presc == PW'(SCAN_DIV - 1));
    assign row_any  = |row_sync;
    assign row_low  = lowest_row(row_sync);
    assign accept   = enable && (state == ST_ACCEPT);
    assign key_code = KEY_W'(int'(row_lat) * COLS + int'(col_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (!enable || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // key_col is written together with col_idx so the drive moves on the tick edge itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_SCAN;
            col_idx  <= '0;
            row_lat  <= '0;
            stab_cnt <= '0;
            rel_cnt  <= '0;
            key_col  <= '0;
        end else if (!enable) begin
            state    <= ST_SCAN;
            col_idx  <= '0;
            stab_cnt <= '0;
            rel_cnt  <= '0;
            key_col  <= '0;
        end else begin
            key_col <= col_onehot(col_idx);
            case (state)
                ST_SCAN: begin
                    if (tick) begin
                        if (row_any) begin
                            row_lat  <= row_low;
                            stab_cnt <= DW'(1);
                            state    <= (DEBOUNCE <= 1) ? ST_ACCEPT : ST_DEBOUNCE;
                        end else begin
                            col_idx <= next_col(col_idx);
                            key_col <= col_onehot(next_col(col_idx));
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (tick) begin
                        if (row_any && (row_low == row_lat)) begin
                            stab_cnt <= stab_cnt + DW'(1);
                            if (stab_cnt + DW'(1) == DW'(DEBOUNCE)) state <= ST_ACCEPT;
                        end else begin
                            stab_cnt <= '0;
                            state    <= ST_SCAN;
                        end
                    end
                end
                ST_ACCEPT: begin
                    rel_cnt <= '0;
                    state   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (tick) begin
                        if (!row_any) begin
                            if (rel_cnt + DW'(1) == DW'(DEBOUNCE)) begin
                                rel_cnt  <= '0;
                                stab_cnt <= '0;
                                col_idx  <= next_col(col_idx);
                                key_col  <= col_onehot(next_col(col_idx));
                                state    <= ST_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + DW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry_reg.sv
// Keypad front end top: digit buffer, special-key decode and entry capture
// on top of the debounced matrix scanner.
module keypad_entry_reg
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int ENTER_CODE = DEF_ENTER_CODE,
    parameter int CLEAR_CODE = DEF_CLEAR_CODE,
    parameter int BKSP_CODE  = DEF_BKSP_CODE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [ROWS-1:0]                  key_row,
    output logic [COLS-1:0]                  key_col,
    output logic [KEY_W*NUM_DIGITS-1:0]      data_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
    output logic                             key_strobe,
    output logic [KEY_W-1:0]                 key_code,
    output logic                             overflow,
    output logic                             entry_valid,
    output logic [KEY_W*NUM_DIGITS-1:0]      entry_data
);

    localparam int DW    = KEY_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic             accept;
    logic [KEY_W-1:0] scan_code;
    logic             is_enter;
    logic             is_clear;
    logic             is_bksp;
    logic             has_digits;
    logic             buf_full;

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .key_row  (key_row),
        .key_col  (key_col),
        .accept   (accept),
        .key_code (scan_code)
    );

    assign is_enter   = (scan_code == KEY_W'(ENTER_CODE));
    assign is_clear   = (scan_code == KEY_W'(CLEAR_CODE));
    assign is_bksp    = (scan_code == KEY_W'(BKSP_CODE));
    assign has_digits = (digit_count != '0);
    assign buf_full   = (digit_count >= CNT_W'(NUM_DIGITS));

    // Everything below changes only on an accept, so a disabled scanner leaves the entry frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            digit_count <= '0;
            key_strobe  <= 1'b0;
            key_code    <= '0;
            overflow    <= 1'b0;
            entry_valid <= 1'b0;
            entry_data  <= '0;
        end else begin
            key_strobe  <= 1'b0;
            overflow    <= 1'b0;
            entry_valid <= 1'b0;
            if (accept) begin
                key_strobe <= 1'b1;
                key_code   <= scan_code;
                if (is_enter) begin
                    if (has_digits) begin
                        entry_data  <= data_out;
                        entry_valid <= 1'b1;
                        data_out    <= '0;
                        digit_count <= '0;
                    end
                end else if (is_clear) begin
                    data_out    <= '0;
                    digit_count <= '0;
                end else if (is_bksp) begin
                    if (has_digits) begin
                        data_out    <= data_out >> KEY_W;
                        digit_count <= digit_count - CNT_W'(1);
                    end
                end else if (!buf_full) begin
                    data_out    <= (data_out << KEY_W) | DW'(scan_code);
                    digit_count <= digit_count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_reg.sv
// Directed bench for keypad_entry_reg with a behavioural 4x4 key matrix.
module tb_keypad_entry_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [15:0] data_out;
    logic [2:0]  digit_count;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic        overflow;
    logic        entry_valid;
    logic [15:0] entry_data;

    logic [15:0] pressed = '0;

    int n_cmp = 0;
    int n_err = 0;
    int strobes, ev_pulses, ov_pulses;
    logic [3:0]  snap_code;
    logic [15:0] snap_data;
    logic [2:0]  snap_cnt;
    logic        snap_ev, snap_ov;
    logic [15:0] snap_ed;

    keypad_entry_reg #(
        .ROWS(4), .COLS(4), .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .key_row     (key_row),
        .key_col     (key_col),
        .data_out    (data_out),
        .digit_count (digit_count),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .overflow    (overflow),
        .entry_valid (entry_valid),
        .entry_data  (entry_data)
    );

    always #5 clk = ~clk;

    // Key k sits at row k/4, column k%4 and connects that row to the driven column
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && key_col[c]) key_row[r] = 1'b1;
    end

    task automatic clear_counts();
        strobes = 0; ev_pulses = 0; ov_pulses = 0;
        snap_code = 'x; snap_data = 'x; snap_cnt = 'x; snap_ev = 'x; snap_ov = 'x; snap_ed = 'x;
    endtask

    task automatic step();
        @(negedge clk);
        if (key_strobe === 1'b1) begin
            strobes++;
            snap_code = key_code; snap_data = data_out; snap_cnt = digit_count;
            snap_ev = entry_valid; snap_ov = overflow; snap_ed = entry_data;
        end
        if (entry_valid === 1'b1) ev_pulses++;
        if (overflow === 1'b1) ov_pulses++;
    endtask

    task automatic press(input logic [15:0] mask, input int hold);
        clear_counts();
        pressed = mask;
        for (int i = 0; i < 300 && strobes == 0; i++) step();
        repeat (hold) step();
        pressed = '0;
        repeat (40) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; pressed = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (key_col !== 4'h0 || key_strobe !== 1'b0 || key_code !== 4'h0) begin
            n_err++; $display("FAIL reset_ctl: col=%h strobe=%b code=%h want 0/0/0", key_col, key_strobe, key_code); end
        n_cmp++; if (data_out !== 16'h0 || digit_count !== 3'd0 || entry_data !== 16'h0) begin
            n_err++; $display("FAIL reset_data: data=%h cnt=%0d entry=%h want 0/0/0", data_out, digit_count, entry_data); end
        n_cmp++; if (overflow !== 1'b0 || entry_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_pulses: ovf=%b ev=%b want 0/0", overflow, entry_valid); end
        rst = 1'b0;
        step();
        n_cmp++; if (key_col !== 4'h0) begin
            n_err++; $display("FAIL col_disabled: got %h want 0", key_col); end
        enable = 1'b1;
        step();
        n_cmp++; if (key_col !== 4'b0001) begin
            n_err++; $display("FAIL col_after_enable: got %b want 0001", key_col); end
    endtask

    task automatic test_single_key();
        press(16'd1 << 6, 8);
        n_cmp++; if (strobes !== 1) begin
            n_err++; $display("FAIL single_strobes: got %0d want 1", strobes); end
        n_cmp++; if (snap_code !== 4'd6) begin
            n_err++; $display("FAIL single_code: got %0d want 6", snap_code); end
        n_cmp++; if (data_out !== 16'h0006 || digit_count !== 3'd1) begin
            n_err++; $display("FAIL single_data: data=%h cnt=%0d want 0006/1", data_out, digit_count); end
    endtask

    task automatic test_enter();
        press(16'd1 << 15, 8);
        press(16'd1 << 1, 8);
        press(16'd1 << 2, 8);
        press(16'd1 << 3, 8);
        press(16'd1 << 14, 8);
        n_cmp++; if (snap_ev !== 1'b1 || snap_ed !== 16'h0123) begin
            n_err++; $display("FAIL enter_capture: ev=%b entry=%h want 1/0123", snap_ev, snap_ed); end
        n_cmp++; if (ev_pulses !== 1) begin
            n_err++; $display("FAIL enter_pulse_len: got %0d cycles want 1", ev_pulses); end
        n_cmp++; if (data_out !== 16'h0 || digit_count !== 3'd0 || entry_data !== 16'h0123) begin
            n_err++; $display("FAIL enter_after: data=%h cnt=%0d entry=%h want 0/0/0123", data_out, digit_count, entry_data); end
    endtask

    task automatic test_overflow();
        int ov_before;
        press(16'd1 << 15, 8);
        ov_before = 0;
        for (int k = 1; k <= 4; k++) begin
            press(16'd1 << k, 8);
            ov_before += ov_pulses;
        end
        n_cmp++; if (data_out !== 16'h1234 || ov_before !== 0) begin
            n_err++; $display("FAIL fill: data=%h ovf_pulses=%0d want 1234/0", data_out, ov_before); end
        press(16'd1 << 5, 8);
        n_cmp++; if (snap_ov !== 1'b1 || ov_pulses !== 1 || ev_pulses !== 0) begin
            n_err++; $display("FAIL overflow_pulse: at_strobe=%b cycles=%0d ev=%0d want 1/1/0", snap_ov, ov_pulses, ev_pulses); end
        n_cmp++; if (data_out !== 16'h1234 || digit_count !== 3'd4) begin
            n_err++; $display("FAIL overflow_hold: data=%h cnt=%0d want 1234/4", data_out, digit_count); end
    endtask

    task automatic test_bksp_clear();
        press(16'd1 << 15, 8);
        press(16'd1 << 1, 8);
        press(16'd1 << 2, 8);
        press(16'd1 << 3, 8);
        press(16'd1 << 13, 8);
        n_cmp++; if (data_out !== 16'h0012 || digit_count !== 3'd2) begin
            n_err++; $display("FAIL bksp: data=%h cnt=%0d want 0012/2", data_out, digit_count); end
        press(16'd1 << 15, 8);
        n_cmp++; if (data_out !== 16'h0000 || digit_count !== 3'd0) begin
            n_err++; $display("FAIL clear: data=%h cnt=%0d want 0000/0", data_out, digit_count); end
        press(16'd1 << 14, 8);
        n_cmp++; if (strobes !== 1 || snap_code !== 4'd14 || ev_pulses !== 0) begin
            n_err++; $display("FAIL empty_enter: strobes=%0d code=%0d ev=%0d want 1/14/0", strobes, snap_code, ev_pulses); end
    endtask

    task automatic test_glitch();
        clear_counts();
        for (int i = 0; i < 40 && key_col === 4'b0010; i++) step();
        for (int i = 0; i < 40 && key_col !== 4'b0010; i++) step();
        pressed = 16'd1 << 5;
        repeat (4) step();
        pressed = '0;
        repeat (40) step();
        n_cmp++; if (strobes !== 0) begin
            n_err++; $display("FAIL glitch: strobes=%0d want 0", strobes); end
    endtask

    task automatic test_multi_row();
        press((16'd1 << 1) | (16'd1 << 9), 8);
        n_cmp++; if (strobes !== 1 || snap_code !== 4'd1) begin
            n_err++; $display("FAIL multi_row: strobes=%0d code=%0d want 1/1", strobes, snap_code); end
    endtask

    task automatic test_hold();
        press(16'd1 << 5, 80);
        n_cmp++; if (strobes !== 1 || snap_code !== 4'd5) begin
            n_err++; $display("FAIL long_hold: strobes=%0d code=%0d want 1/5", strobes, snap_code); end
    endtask

    task automatic test_reset_in_release();
        press(16'd1 << 15, 8);
        clear_counts();
        pressed = 16'd1 << 7;
        for (int i = 0; i < 300 && strobes == 0; i++) step();
        repeat (6) step();
        rst = 1'b1;
        #1;
        n_cmp++; if (key_col !== 4'h0 || data_out !== 16'h0 || digit_count !== 3'd0 || key_code !== 4'h0 || entry_data !== 16'h0) begin
            n_err++; $display("FAIL mid_reset: col=%h data=%h cnt=%0d code=%h entry=%h want all 0", key_col, data_out, digit_count, key_code, entry_data); end
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 300 && strobes == 0; i++) step();
        repeat (20) step();
        n_cmp++; if (strobes !== 1 || snap_code !== 4'd7 || snap_data !== 16'h0007 || snap_cnt !== 3'd1) begin
            n_err++; $display("FAIL reaccept: strobes=%0d code=%0d data=%h cnt=%0d want 1/7/0007/1", strobes, snap_code, snap_data, snap_cnt); end
        pressed = '0;
        repeat (40) step();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        clear_counts();
        step();
        n_cmp++; if (key_col !== 4'h0 || data_out !== 16'h0007) begin
            n_err++; $display("FAIL disable: col=%h data=%h want 0/0007", key_col, data_out); end
        pressed = 16'd1 << 3;
        repeat (40) step();
        n_cmp++; if (strobes !== 0 || data_out !== 16'h0007 || digit_count !== 3'd1) begin
            n_err++; $display("FAIL disabled_press: strobes=%0d data=%h cnt=%0d want 0/0007/1", strobes, data_out, digit_count); end
        pressed = '0;
        enable = 1'b1;
        step();
        n_cmp++; if (key_col !== 4'b0001) begin
            n_err++; $display("FAIL reenable_col: got %b want 0001", key_col); end
        press(16'd1 << 2, 8);
        n_cmp++; if (data_out !== 16'h0072 || digit_count !== 3'd2) begin
            n_err++; $display("FAIL reenable_key: data=%h cnt=%0d want 0072/2", data_out, digit_count); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_single_key();
        test_enter();
        test_overflow();
        test_bksp_clear();
        test_glitch();
        test_multi_row();
        test_hold();
        test_reset_in_release();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
